// File: rtl/cla_multiword_seq_if.sv
// Request/result bundle between a requester and the multi-word CLA sequencer.
// The requester is the master; the sequencer is the slave.
interface cla_multiword_seq_if #(
    parameter int WORDS = 4
);
    logic                  start;
    logic                  op_sub;
    logic                  cin;
    logic [32*WORDS-1:0]   a;
    logic [32*WORDS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [32*WORDS-1:0]   sum;
    logic                  cout;
    logic                  ovf;

    modport master (
        output start, op_sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cla_multiword_seq.sv
// Wide add/subtract built from one shared 32-bit carry-lookahead adder,
// stepping one word per cycle (LS word first) with the carry held in a register.
module cla_multiword_seq #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    cla_multiword_seq_if.slave bus
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic {IDLE, RUN} stateT;

    stateT                   state_q;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic [WORDS-1:0][31:0]  a_q;
    logic [WORDS-1:0][31:0]  bEff_q;
    logic [WORDS-1:0][31:0]  sum_q;
    logic                    busy_q, done_q, cout_q, ovf_q;

    logic [31:0] aWord, bWord, claSum;
    logic        claCout;
    logic [31:0] gen, prop;
    logic [7:0]  grpGen, grpProp;
    logic [8:0]  grpCarry;
    logic [32:0] carry;

    assign aWord = a_q[idx_q];
    assign bWord = bEff_q[idx_q];

    // Two-level lookahead: 4-bit group generate/propagate, then per-bit carries inside each group.
    always_comb begin
        gen      = aWord & bWord;
        prop     = aWord ^ bWord;
        grpGen   = '0;
        grpProp  = '0;
        grpCarry = '0;
        carry    = '0;
        for (int g = 0; g < 8; g++) begin
            grpGen[g]  = gen[4*g+3]
                       | (prop[4*g+3] & gen[4*g+2])
                       | (prop[4*g+3] & prop[4*g+2] & gen[4*g+1])
                       | (prop[4*g+3] & prop[4*g+2] & prop[4*g+1] & gen[4*g]);
            grpProp[g] = &prop[4*g +: 4];
        end
        grpCarry[0] = carry_q;
        for (int g = 0; g < 8; g++) begin
            grpCarry[g+1] = grpGen[g] | (grpProp[g] & grpCarry[g]);
        end
        for (int g = 0; g < 8; g++) begin
            carry[4*g] = grpCarry[g];
            for (int k = 0; k < 3; k++) begin
                carry[4*g+k+1] = gen[4*g+k] | (prop[4*g+k] & carry[4*g+k]);
            end
        end
        carry[32] = grpCarry[8];
        claSum    = prop ^ carry[31:0];
        claCout   = carry[32];
    end

    assign idx_d   = idx_q + 1'b1;
    assign carry_d = claCout;

    // Subtraction is folded into the operands at accept time so RUN only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            bEff_q  <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        bEff_q  <= bus.op_sub ? ~bus.b : bus.b;
                        carry_q <= bus.op_sub ? 1'b1 : bus.cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= claSum;
                    carry_q      <= carry_d;
                    idx_q        <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= claCout;
                        ovf_q   <= (aWord[31] == bWord[31]) & (claSum[31] != aWord[31]);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
